// File: rtl/kb_num_entry.sv
// ---------------------------------------------------------------------------
// kb_num_entry
//
// Numeric entry stage that sits behind the PS/2 scan-code receiver. It collects
// released-key scan codes (set 2) into a small BCD buffer for display. It
// supports Backspace and Esc editing. On Enter it converts the buffer to binary
// one digit per clock and offers the result downstream with a valid/ack
// handshake.
//
// Parameters
//   N_DIGITS  maximum number of decimal digits held in the entry buffer
//   W         width of the binary result; 2**W must exceed 10**N_DIGITS - 1
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   code_tick  one-cycle pulse when a key is released; key_code follows a cycle later
//   key_code   set-2 scan code of the released key
//   num_ack    downstream has taken num (only honoured while holding a result)
//   bcd        entry buffer; nibble [3:0] is the most recently typed digit
//   digit_cnt  number of digits currently held
//   num        converted binary value; kept until the next conversion
//   num_valid  num is valid; held high until acknowledged
//   busy       converting or holding a result; keys are dropped while high
//   err_tick   one-cycle pulse on a rejected key
// ---------------------------------------------------------------------------
module kb_num_entry #(
    parameter int N_DIGITS = 2,
    parameter int W        = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              code_tick,
    input  logic [7:0]                        key_code,
    input  logic                              num_ack,
    output logic [4*N_DIGITS-1:0]             bcd,
    output logic [$clog2(N_DIGITS+1)-1:0]     digit_cnt,
    output logic [W-1:0]                      num,
    output logic                              num_valid,
    output logic                              busy,
    output logic                              err_tick
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(N_DIGITS + 1);
    // The digit index needs at least one bit even for a one-digit buffer.
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CONV,
        ST_HOLD
    } state_t;

    typedef enum logic [2:0] {
        K_DIGIT,
        K_ENTER,
        K_BKSP,
        K_ESC,
        K_INVALID
    } key_kind_t;

    state_t           state;
    logic             tick_d;
    logic [W-1:0]     acc;
    logic [IDX_W-1:0] idx;

    key_kind_t        key_kind;
    logic [3:0]       key_digit;
    logic [3:0]       cur_nibble;
    logic [W-1:0]     acc_next;

    // -----------------------------------------------------------------------
    // Scan-code decode. The result is only used in the tick_d cycle, when the
    // upstream key_code register has caught up with its tick.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        key_kind  = K_INVALID;
        key_digit = 4'd0;
        case (key_code)
            8'h45: begin key_kind = K_DIGIT; key_digit = 4'd0; end
            8'h16: begin key_kind = K_DIGIT; key_digit = 4'd1; end
            8'h1E: begin key_kind = K_DIGIT; key_digit = 4'd2; end
            8'h26: begin key_kind = K_DIGIT; key_digit = 4'd3; end
            8'h25: begin key_kind = K_DIGIT; key_digit = 4'd4; end
            8'h2E: begin key_kind = K_DIGIT; key_digit = 4'd5; end
            8'h36: begin key_kind = K_DIGIT; key_digit = 4'd6; end
            8'h3D: begin key_kind = K_DIGIT; key_digit = 4'd7; end
            8'h3E: begin key_kind = K_DIGIT; key_digit = 4'd8; end
            8'h46: begin key_kind = K_DIGIT; key_digit = 4'd9; end
            8'h5A: key_kind = K_ENTER;
            8'h66: key_kind = K_BKSP;
            8'h76: key_kind = K_ESC;
            default: key_kind = K_INVALID;
        endcase
    end

    // -----------------------------------------------------------------------
    // Conversion datapath. Horner's rule starts at the oldest digit, which is
    // the highest occupied nibble. acc*10 is formed as (acc<<3)+(acc<<1).
    // -----------------------------------------------------------------------
    assign cur_nibble = bcd[{idx, 2'b00} +: 4];
    assign acc_next   = W'((acc << 3) + (acc << 1) + W'(cur_nibble));

    // -----------------------------------------------------------------------
    // Control FSM and all registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ENTRY;
            tick_d    <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            bcd       <= '0;
            digit_cnt <= '0;
            num       <= '0;
            num_valid <= 1'b0;
            busy      <= 1'b0;
            err_tick  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // right-hand side below sees the value from before this edge.
            tick_d   <= code_tick;
            err_tick <= 1'b0;

            case (state)
                ST_ENTRY: begin
                    if (tick_d) begin
                        case (key_kind)
                            K_DIGIT: begin
                                if (digit_cnt < CNT_W'(N_DIGITS)) begin
                                    bcd       <= (bcd << 4) | BCD_W'(key_digit);
                                    digit_cnt <= digit_cnt + 1'b1;
                                end else begin
                                    err_tick <= 1'b1;
                                end
                            end
                            K_BKSP: begin
                                // Backspace on an empty buffer is a harmless no-op.
                                if (digit_cnt != '0) begin
                                    bcd       <= bcd >> 4;
                                    digit_cnt <= digit_cnt - 1'b1;
                                end
                            end
                            K_ESC: begin
                                bcd       <= '0;
                                digit_cnt <= '0;
                            end
                            K_ENTER: begin
                                if (digit_cnt != '0) begin
                                    acc   <= '0;
                                    idx   <= IDX_W'(digit_cnt - 1'b1);
                                    busy  <= 1'b1;
                                    state <= ST_CONV;
                                end else begin
                                    err_tick <= 1'b1;
                                end
                            end
                            default: err_tick <= 1'b1;
                        endcase
                    end
                end

                ST_CONV: begin
                    // One digit per clock. The buffer stays visible for
                    // display until the result is acknowledged.
                    acc <= acc_next;
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        num       <= acc_next;
                        num_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (num_ack) begin
                        num_valid <= 1'b0;
                        bcd       <= '0;
                        digit_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= ST_ENTRY;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kb_num_entry.sv
// ---------------------------------------------------------------------------
// tb_kb_num_entry
//
// Self-checking bench for kb_num_entry. It has three parts. A vector table
// covers the editing keys. Hand-written sequences cover conversion latency,
// dropped keys, the ack timing and reset during a conversion. A randomized key
// stream is checked against a model that holds the typed digits in a queue.
// ---------------------------------------------------------------------------
module tb_kb_num_entry;

    localparam int N = 2;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           reset;
    logic           code_tick;
    logic [7:0]     key_code;
    logic           num_ack;
    logic [4*N-1:0] bcd;
    logic [1:0]     digit_cnt;
    logic [W-1:0]   num;
    logic           num_valid;
    logic           busy;
    logic           err_tick;

    kb_num_entry #(.N_DIGITS(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .code_tick (code_tick),
        .key_code  (key_code),
        .num_ack   (num_ack),
        .bcd       (bcd),
        .digit_cnt (digit_cnt),
        .num       (num),
        .num_valid (num_valid),
        .busy      (busy),
        .err_tick  (err_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    typedef struct {
        logic [7:0] code;
        logic [7:0] e_bcd;
        int         e_cnt;
        bit         e_err;
    } vec_t;

    // Editing vectors, applied in order from an empty buffer.
    vec_t vecs [14] = '{
        '{8'h66, 8'h00, 0, 1'b0},   // BKSP on empty: no-op, no error
        '{8'h5A, 8'h00, 0, 1'b1},   // ENTER on empty: error
        '{8'h1C, 8'h00, 0, 1'b1},   // invalid code
        '{8'h46, 8'h09, 1, 1'b0},
        '{8'h46, 8'h99, 2, 1'b0},
        '{8'h45, 8'h99, 2, 1'b1},   // buffer full
        '{8'h66, 8'h09, 1, 1'b0},
        '{8'h76, 8'h00, 0, 1'b0},   // ESC
        '{8'h16, 8'h01, 1, 1'b0},
        '{8'h16, 8'h11, 2, 1'b0},
        '{8'h76, 8'h00, 0, 1'b0},
        '{8'h26, 8'h03, 1, 1'b0},
        '{8'h66, 8'h00, 0, 1'b0},
        '{8'h3E, 8'h08, 1, 1'b0}
    };

    // Reference model: the typed digits, oldest first.
    int q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_bcd();
        logic [31:0] b = 0;
        foreach (q[i]) b = (b << 4) | q[i];
        return b;
    endfunction

    function automatic int m_val();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    function automatic bit is_mapped(input logic [7:0] c);
        foreach (dcode[i]) if (dcode[i] == c) return 1'b1;
        return (c == 8'h5A) || (c == 8'h66) || (c == 8'h76);
    endfunction

    // Sends a tick in one cycle and the code in the next, the same way the
    // upstream stage does. The cycle of the tick carries a decoy code. The
    // checks run in the cycle after the key is consumed, where err_tick must
    // show.
    task automatic send_key(input logic [7:0] code, input logic [31:0] e_bcd, input int e_cnt,
                            input bit e_err, input bit e_busy, input string tag);
        @(posedge clk); #1;
        code_tick = 1'b1;
        key_code  = (code == 8'h16) ? 8'h1C : 8'h16;
        @(posedge clk); #1;
        code_tick = 1'b0;
        key_code  = code;
        @(posedge clk); #1;
        key_code  = ~code;
        check({tag, " bcd"},       bcd,       e_bcd);
        check({tag, " digit_cnt"}, digit_cnt, e_cnt);
        check({tag, " err_tick"},  err_tick,  e_err);
        check({tag, " busy"},      busy,      e_busy);
    endtask

    // ENTER on a non-empty buffer. num_valid must rise exactly
    // 2+dc cycles after the ENTER tick, hold for ack_delay cycles, then
    // clear together with the buffer.
    task automatic do_enter(input int exp_val, input int dc, input logic [31:0] e_bcd,
                            input int ack_delay, input string tag);
        send_key(8'h5A, e_bcd, dc, 1'b0, 1'b1, {tag, " enter"});
        repeat (dc - 1) begin
            @(posedge clk); #1;
            check({tag, " conv num_valid"}, num_valid, 0);
            check({tag, " conv busy"},      busy,      1);
        end
        @(posedge clk); #1;
        check({tag, " num_valid rise"}, num_valid, 1);
        check({tag, " num"},            num,       exp_val);
        repeat (ack_delay) begin
            @(posedge clk); #1;
            check({tag, " hold num_valid"}, num_valid, 1);
            check({tag, " hold num"},       num,       exp_val);
        end
        num_ack = 1'b1;
        @(posedge clk); #1;
        num_ack = 1'b0;
        check({tag, " ack num_valid"}, num_valid, 0);
        check({tag, " ack busy"},      busy,      0);
        check({tag, " ack bcd"},       bcd,       0);
        check({tag, " ack digit_cnt"}, digit_cnt, 0);
        check({tag, " num kept"},      num,       exp_val);
    endtask

    initial begin
        reset     = 1'b1;
        code_tick = 1'b0;
        key_code  = 8'h00;
        num_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset bcd",       bcd,       0);
        check("reset digit_cnt", digit_cnt, 0);
        check("reset num",       num,       0);
        check("reset num_valid", num_valid, 0);
        check("reset busy",      busy,      0);
        check("reset err_tick",  err_tick,  0);
        reset = 1'b0;

        // Table-driven editing vectors.
        for (int i = 0; i < 14; i++)
            send_key(vecs[i].code, vecs[i].e_bcd, vecs[i].e_cnt, vecs[i].e_err, 1'b0,
                     $sformatf("vec%0d", i));
        do_enter(8, 1, 8'h08, 1, "enter8");

        // 1, 2 -> 12. num_ack is ignored in ENTRY. A key and an ack are
        // dropped during CONV, and a key is dropped during HOLD.
        send_key(8'h16, 8'h01, 1, 1'b0, 1'b0, "k1");
        send_key(8'h1E, 8'h12, 2, 1'b0, 1'b0, "k2");
        @(posedge clk); #1;
        num_ack = 1'b1;
        @(posedge clk); #1;
        num_ack = 1'b0;
        check("ack in entry bcd",       bcd,       8'h12);
        check("ack in entry digit_cnt", digit_cnt, 2);
        send_key(8'h5A, 8'h12, 2, 1'b0, 1'b1, "enter12");
        code_tick = 1'b1;
        num_ack   = 1'b1;
        @(posedge clk); #1;
        code_tick = 1'b0;
        num_ack   = 1'b0;
        key_code  = 8'h16;
        check("conv12 num_valid", num_valid, 0);
        check("conv12 busy",      busy,      1);
        @(posedge clk); #1;
        check("hold12 num_valid", num_valid, 1);
        check("hold12 num",       num,       12);
        check("conv key err",     err_tick,  0);
        check("conv key bcd",     bcd,       8'h12);
        send_key(8'h16, 8'h12, 2, 1'b0, 1'b1, "hold key");
        check("hold key num_valid", num_valid, 1);
        num_ack = 1'b1;
        @(posedge clk); #1;
        num_ack = 1'b0;
        check("ack12 num_valid", num_valid, 0);
        check("ack12 bcd",       bcd,       0);
        check("ack12 digit_cnt", digit_cnt, 0);

        // 9, 9, 0 (rejected) -> 99. The ack comes in the first HOLD cycle.
        send_key(8'h46, 8'h09, 1, 1'b0, 1'b0, "n9a");
        send_key(8'h46, 8'h99, 2, 1'b0, 1'b0, "n9b");
        send_key(8'h45, 8'h99, 2, 1'b1, 1'b0, "n0 full");
        do_enter(99, 2, 8'h99, 0, "enter99");

        // Asynchronous reset in the CONV cycle, then a fresh entry.
        send_key(8'h16, 8'h01, 1, 1'b0, 1'b0, "pre-rst");
        send_key(8'h5A, 8'h01, 1, 1'b0, 1'b1, "enter rst");
        #1 reset = 1'b1;
        #1;
        check("async rst bcd",       bcd,       0);
        check("async rst digit_cnt", digit_cnt, 0);
        check("async rst num",       num,       0);
        check("async rst num_valid", num_valid, 0);
        check("async rst busy",      busy,      0);
        check("async rst err_tick",  err_tick,  0);
        #2 reset = 1'b0;
        send_key(8'h2E, 8'h05, 1, 1'b0, 1'b0, "n5");
        do_enter(5, 1, 8'h05, 2, "enter5");

        // Randomized key stream against the queue model.
        q.delete();
        for (int it = 0; it < 300; it++) begin
            int r;
            string tag;
            tag = $sformatf("rnd%0d", it);
            r = $urandom_range(0, 99);
            if (r < 55) begin
                int d;
                bit e;
                d = $urandom_range(0, 9);
                e = (q.size() >= N);
                if (!e) q.push_back(d);
                send_key(dcode[d], m_bcd(), q.size(), e, 1'b0, tag);
            end else if (r < 67) begin
                if (q.size() == 0)
                    send_key(8'h5A, 0, 0, 1'b1, 1'b0, tag);
                else begin
                    do_enter(m_val(), q.size(), m_bcd(), $urandom_range(0, 3), tag);
                    q.delete();
                end
            end else if (r < 79) begin
                if (q.size() > 0) void'(q.pop_back());
                send_key(8'h66, m_bcd(), q.size(), 1'b0, 1'b0, tag);
            end else if (r < 86) begin
                q.delete();
                send_key(8'h76, 0, 0, 1'b0, 1'b0, tag);
            end else begin
                logic [7:0] c;
                c = 8'($urandom_range(0, 255));
                while (is_mapped(c)) c = 8'($urandom_range(0, 255));
                send_key(c, m_bcd(), q.size(), 1'b1, 1'b0, tag);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
